// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU with RV32I base ops and an optional M extension.
// Define ALU_SEQ_MULDIV_EN to build the registered multiplier and the iterative divider.
// Without it, codes 16..23 return 0 with latency 1 and the DIV state is never entered.
//
// state | meaning
// IDLE  | ready for a new op; in_ready high
// DIV   | restoring divider iterating, one quotient bit per cycle, then sign fix-up
// DONE  | result/zero presented with out_valid; held until out_ready
module alu_seq #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     x,
    input  logic [XLEN-1:0]     y,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                zero,
    output logic                busy
);

    localparam int SW = $clog2(XLEN);

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(9);
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [ALU_OP_W-1:0] OP_MUL    = ALU_OP_W'(16);
    localparam logic [ALU_OP_W-1:0] OP_MULH   = ALU_OP_W'(17);
    localparam logic [ALU_OP_W-1:0] OP_MULHSU = ALU_OP_W'(18);
    localparam logic [ALU_OP_W-1:0] OP_MULHU  = ALU_OP_W'(19);
    localparam logic [ALU_OP_W-1:0] OP_DIV    = ALU_OP_W'(20);
    localparam logic [ALU_OP_W-1:0] OP_DIVU   = ALU_OP_W'(21);
    localparam logic [ALU_OP_W-1:0] OP_REM    = ALU_OP_W'(22);
    localparam logic [ALU_OP_W-1:0] OP_REMU   = ALU_OP_W'(23);
    localparam logic [XLEN-1:0]     SMIN      = {1'b1, {(XLEN-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     shamt;
    logic [XLEN-1:0]   alu_res;
    logic              div_start;

    assign shamt = y[SW-1:0];

`ifdef ALU_SEQ_MULDIV_EN
    logic signed [XLEN:0]   mul_a, mul_b;
    logic [2*XLEN-1:0]      prod;
    logic                   sgn_div, ovf, x_neg, y_neg;
    logic [XLEN-1:0]        x_abs, y_abs;

    logic [XLEN-1:0]        dv_q, dv_r, dv_d;
    logic [SW-1:0]          dv_cnt;
    logic                   dv_fix, dv_rem, dv_neg;
    logic [XLEN:0]          dv_rsh, dv_rsub;
    logic [XLEN-1:0]        dv_rnext, dv_res;
    logic                   dv_ge;

    // Operand conditioning: multiplier sign extension, divide magnitudes and special cases.
    always_comb begin
        mul_a   = {((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) & x[XLEN-1], x};
        mul_b   = {(alu_op == OP_MULH) & y[XLEN-1], y};
        prod    = $unsigned((2*XLEN)'(mul_a) * (2*XLEN)'(mul_b));
        sgn_div = (alu_op == OP_DIV) || (alu_op == OP_REM);
        x_neg   = sgn_div & x[XLEN-1];
        y_neg   = sgn_div & y[XLEN-1];
        x_abs   = x_neg ? -x : x;
        y_abs   = y_neg ? -y : y;
        ovf     = sgn_div && (x == SMIN) && (y == '1);
    end

    // One restoring step on the partial remainder plus the signed fix-up of the final value.
    always_comb begin
        dv_rsh   = {dv_r, dv_q[XLEN-1]};
        dv_rsub  = dv_rsh - {1'b0, dv_d};
        dv_ge    = ~dv_rsub[XLEN];
        dv_rnext = dv_ge ? dv_rsub[XLEN-1:0] : dv_rsh[XLEN-1:0];
        if (dv_rem) dv_res = dv_neg ? -dv_r : dv_r;
        else        dv_res = dv_neg ? -dv_q : dv_q;
    end
`endif

    // Single-cycle result for every op; long divides only raise div_start.
    always_comb begin
        alu_res   = '0;
        div_start = 1'b0;
        case (alu_op)
            OP_ADD:  alu_res = x + y;
            OP_SUB:  alu_res = x - y;
            OP_SLL:  alu_res = x << shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, x < y};
            OP_XOR:  alu_res = x ^ y;
            OP_SRL:  alu_res = x >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(x) >>> shamt);
            OP_OR:   alu_res = x | y;
            OP_AND:  alu_res = x & y;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL:  alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (y == '0)  alu_res = '1;
                else if (ovf) alu_res = x;
                else          div_start = 1'b1;
            end
            OP_REM, OP_REMU: begin
                if (y == '0)  alu_res = x;
                else if (ovf) alu_res = '0;
                else          div_start = 1'b1;
            end
`endif
            default: alu_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: if (in_valid) state_nxt = div_start ? ST_DIV : ST_DONE;
`ifdef ALU_SEQ_MULDIV_EN
            ST_DIV:  if (dv_fix) state_nxt = ST_DONE;
`else
            ST_DIV:  state_nxt = ST_IDLE;
`endif
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result/zero registers and divider datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
            dv_q   <= '0;
            dv_r   <= '0;
            dv_d   <= '0;
            dv_cnt <= '0;
            dv_fix <= 1'b0;
            dv_rem <= 1'b0;
            dv_neg <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && !div_start) begin
                        result <= alu_res;
                        zero   <= (alu_res == '0);
                    end
`ifdef ALU_SEQ_MULDIV_EN
                    if (in_valid && div_start) begin
                        dv_q   <= x_abs;
                        dv_r   <= '0;
                        dv_d   <= y_abs;
                        dv_cnt <= SW'(XLEN-1);
                        dv_fix <= 1'b0;
                        dv_rem <= (alu_op == OP_REM) || (alu_op == OP_REMU);
                        dv_neg <= (alu_op == OP_REM) ? x_neg : (x_neg ^ y_neg);
                    end
`endif
                end
`ifdef ALU_SEQ_MULDIV_EN
                ST_DIV: begin
                    if (dv_fix) begin
                        result <= dv_res;
                        zero   <= (dv_res == '0);
                        dv_fix <= 1'b0;
                    end else begin
                        dv_r <= dv_rnext;
                        dv_q <= {dv_q[XLEN-2:0], dv_ge};
                        if (dv_cnt == '0) dv_fix <= 1'b1;
                        else              dv_cnt <= dv_cnt - 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (XLEN=32 main instance, XLEN=16 shift instance).
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [31:0] x, y, result;
    logic [4:0]  alu_op;

    logic        v16, rdy16, ov16, or16, z16, b16;
    logic [15:0] x16, y16, res16;
    logic [4:0]  op16;

    int n_chk = 0;
    int n_err = 0;
    int lat;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(32), .ALU_OP_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .alu_op(alu_op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    alu_seq #(.XLEN(16), .ALU_OP_W(5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16),
        .x(x16), .y(y16), .alu_op(op16), .out_valid(ov16),
        .out_ready(or16), .result(res16), .zero(z16), .busy(b16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op, wait for the accept edge, then count edges until out_valid.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int l);
        @(negedge clk);
        alu_op = op; x = a; y = b; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 0;
        while (l < 100) begin
            @(posedge clk);
            #1;
            l++;
            if (out_valid) break;
        end
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int elat);
        int l;
        issue(op, a, b, l);
        chk({tag, " latency"}, l, elat);
        chk(tag, result, exp);
        chk({tag, " zero"}, zero, (exp == 32'd0));
        take();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; alu_op = '0;
        v16 = 1'b0; or16 = 1'b0; x16 = '0; y16 = '0; op16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset zero", zero, 1);
        chk("reset in_ready", in_ready, 1);
        chk("reset busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle out_valid", out_valid, 0);
        chk("idle in_ready", in_ready, 1);

        run("ADD",   5'd0,  32'd7,         32'd9,         32'd16,        1);
        run("SUB",   5'd8,  32'd5,         32'd5,         32'd0,         1);
        run("SUB wrap", 5'd8, 32'd0,       32'd1,         32'hFFFF_FFFF, 1);
        run("SRA",   5'd9,  32'h8000_0000, 32'd4,         32'hF800_0000, 1);
        run("SRL",   5'd5,  32'h8000_0000, 32'd4,         32'h0800_0000, 1);
        run("SLT",   5'd2,  32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        run("SLTU",  5'd3,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
        run("SLL",   5'd1,  32'd1,         32'd33,        32'd2,         1);
        run("XOR",   5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        run("OR",    5'd6,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1);
        run("AND",   5'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        run("other", 5'd10, 32'd3,         32'd4,         32'd0,         1);

        // Backpressure: result held, a competing op is ignored while not ready.
        issue(5'd0, 32'd7, 32'd9, lat);
        chk("bp latency", lat, 1);
        @(negedge clk);
        alu_op = 5'd8; x = 32'd100; y = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp result", result, 32'd16);
            chk("bp out_valid", out_valid, 1);
            chk("bp in_ready", in_ready, 0);
            chk("bp busy", busy, 1);
        end
        in_valid = 1'b0;
        take();
        chk("bp released in_ready", in_ready, 1);
        chk("bp released out_valid", out_valid, 0);
        chk("bp released busy", busy, 0);
        chk("bp released result", result, 32'd16);

`ifdef ALU_SEQ_MULDIV_EN
        run("DIV -7/2",  5'd20, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("REM -7/2",  5'd22, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run("DIV 7/-2",  5'd20, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("REM 7/-2",  5'd22, 32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        run("DIVU 100/7", 5'd21, 32'd100,      32'd7,         32'd14,        33);
        run("REMU 100/7", 5'd23, 32'd100,      32'd7,         32'd2,         33);
        run("DIVU 100/0", 5'd21, 32'd100,      32'd0,         32'hFFFF_FFFF, 1);
        run("REMU 100/0", 5'd23, 32'd100,      32'd0,         32'd100,       1);
        run("DIV ovf",   5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("REM ovf",   5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        run("MULHU",     5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run("MUL",       5'd16, 32'd3,         32'hFFFF_FFFE, 32'hFFFF_FFFA, 1);
        run("MULH",      5'd17, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        run("MULHSU",    5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        // Reset in the middle of a divide: nothing is presented afterwards.
        @(negedge clk);
        alu_op = 5'd20; x = 32'hFFFF_FFF9; y = 32'd2; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("div mid busy", busy, 1);
        chk("div mid out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("div rst in_ready", in_ready, 1);
        chk("div rst out_valid", out_valid, 0);
        chk("div rst result", result, 0);
        chk("div rst zero", zero, 1);
        repeat (40) begin
            @(posedge clk);
            #1;
            chk("div rst stays idle", out_valid, 0);
        end
`else
        run("MULHU off", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1);
        run("DIV off",   5'd20, 32'hFFFF_FFF9, 32'd2,         32'd0, 1);
        run("REMU off",  5'd23, 32'd100,       32'd0,         32'd0, 1);

        // Reset while a result is being held.
        issue(5'd0, 32'd3, 32'd4, lat);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("hold rst in_ready", in_ready, 1);
        chk("hold rst out_valid", out_valid, 0);
        chk("hold rst result", result, 0);
        chk("hold rst zero", zero, 1);
`endif
        run("ADD after rst", 5'd0, 32'd1, 32'd1, 32'd2, 1);

        // XLEN=16 shift uses only y[3:0].
        @(negedge clk);
        op16 = 5'd1; x16 = 16'h0001; y16 = 16'h0013; v16 = 1'b1;
        @(posedge clk);
        #1;
        v16 = 1'b0;
        @(posedge clk);
        #1;
        chk("x16 SLL valid", ov16, 1);
        chk("x16 SLL", res16, 32'h0008);
        chk("x16 SLL zero", z16, 0);
        @(negedge clk);
        or16 = 1'b1;
        @(posedge clk);
        #1;
        or16 = 1'b0;
        chk("x16 idle", rdy16, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
